// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and lane helpers for the LSU memory stage
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enable pattern for an access of the given size at an already-aligned offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << addr_lo;
      2'b01:   m = addr_lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed lane(s) of a read word and sign/zero extends
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   data = {24'b0, lane_b};
      F3_HU:   data = {16'b0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - M-stage load/store unit with a stalling single-outstanding memory handshake
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread_m,
  input  logic                  memwrite_m,
  input  logic [2:0]            funct3_m,
  input  logic [DATA_WIDTH-1:0] aluresult_m,
  input  logic [DATA_WIDTH-1:0] writedata_m,
  output logic [DATA_WIDTH-1:0] readdata_m,
  output logic                  stall_m,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  misalign_m,
`endif
  input  logic                  dmem_ack
);

  lsu_state_t            state;
  logic                  is_op;
  logic                  legal_size;
  logic                  misaligned;
  logic                  start;
  logic [1:0]            size;
  logic [1:0]            lo_aligned;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            lo_q;

  // Low address bits are forced to natural alignment; only matters when the trap is disabled.
  always_comb begin
    size       = funct3_m[1:0];
    is_op      = memread_m | memwrite_m;
    legal_size = (size != 2'b11);
    case (size)
      2'b01:   lo_aligned = {aluresult_m[1], 1'b0};
      2'b10:   lo_aligned = 2'b00;
      default: lo_aligned = aluresult_m[1:0];
    endcase
    case (size)
      2'b00:   wdata_rep = {4{writedata_m[7:0]}};
      2'b01:   wdata_rep = {2{writedata_m[15:0]}};
      default: wdata_rep = writedata_m;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic trap;
  assign misaligned = ((size == 2'b01) && aluresult_m[0]) ||
                      ((size == 2'b10) && (aluresult_m[1:0] != 2'b00));
  assign trap       = (state == ST_IDLE) && is_op && legal_size && misaligned;
`else
  assign misaligned = 1'b0;
`endif

  assign start      = (state == ST_IDLE) && is_op && legal_size && !misaligned;
  assign stall_m    = start || (state == ST_BUSY);
  assign dmem_req   = (state == ST_BUSY);
  assign dmem_we    = dmem_req && we_q;
  assign dmem_be    = dmem_req ? be_q : 4'b0000;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  lsu_load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      lo_q       <= 2'b00;
      readdata_m <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_m <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= {aluresult_m[DATA_WIDTH-1:2], 2'b00};
            wdata_q <= wdata_rep;
            be_q    <= lane_mask(size, lo_aligned);
            we_q    <= memwrite_m;
            f3_q    <= funct3_m;
            lo_q    <= lo_aligned;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            readdata_m <= we_q ? '0 : load_data;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_m <= trap;
      if (trap) readdata_m <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - randomized and directed bench for lsu_mem_stage with a behavioural memory-access model
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread_m, memwrite_m;
  logic [2:0]  funct3_m;
  logic [31:0] aluresult_m, writedata_m;
  logic [31:0] readdata_m;
  logic        stall_m, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_m;
`endif

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rd;

  lsu_mem_stage #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .memread_m   (memread_m),
    .memwrite_m  (memwrite_m),
    .funct3_m    (funct3_m),
    .aluresult_m (aluresult_m),
    .writedata_m (writedata_m),
    .readdata_m  (readdata_m),
    .stall_m     (stall_m),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_rdata  (dmem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_m  (misalign_m),
`endif
    .dmem_ack    (dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction sitting in M: drive it, follow the handshake, compare to the model.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdat, input int delay);
    logic [1:0]  sz;
    logic        legal, mis;
    logic [31:0] ma, ewd, sh, ld;
    logic [3:0]  ebe;
    int          nstall;
    sz    = f3[1:0];
    legal = (sz != 2'b11);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((sz == 2'd1) && addr[0]) || ((sz == 2'd2) && (addr[1:0] != 2'd0));
`endif
    ma  = (sz == 2'd1) ? (addr & ~32'd1) : (sz == 2'd2) ? (addr & ~32'd3) : addr;
    ebe = (sz == 2'd0) ? 4'(1 << ma[1:0]) : (sz == 2'd1) ? 4'(3 << ma[1:0]) : 4'hF;
    ewd = (sz == 2'd0) ? (wd & 32'hFF) * 32'h0101_0101 :
          (sz == 2'd1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    sh  = rdat >> (8 * ma[1:0]);
    case (f3)
      3'd0:    ld = (sh & 32'h80) != 0 ? (sh | 32'hFFFF_FF00) : (sh & 32'hFF);
      3'd1:    ld = (sh & 32'h8000) != 0 ? (sh | 32'hFFFF_0000) : (sh & 32'hFFFF);
      3'd4:    ld = sh & 32'hFF;
      3'd5:    ld = sh & 32'hFFFF;
      default: ld = rdat;
    endcase

    memread_m   = rd;
    memwrite_m  = wr;
    funct3_m    = f3;
    aluresult_m = addr;
    writedata_m = wd;
    dmem_rdata  = $urandom;
    dmem_ack    = 1'b0;
    #1;
    chk("stall_idle", 32'(stall_m), 32'(legal && !mis));
    chk("req_idle", 32'(dmem_req), 32'd0);
    if (!legal || mis) begin
      tick();
      memread_m  = 1'b0;
      memwrite_m = 1'b0;
      #1;
      chk("req_noop", 32'(dmem_req), 32'd0);
      chk("stall_noop", 32'(stall_m), 32'd0);
      if (mis) exp_rd = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misalign_pulse", 32'(misalign_m), 32'(mis));
`endif
      chk("rd_noop", readdata_m, exp_rd);
`ifdef LSU_MISALIGN_TRAP_EN
      tick();
      chk("misalign_clear", 32'(misalign_m), 32'd0);
`endif
      return;
    end
    nstall = stall_m ? 1 : 0;
    tick();
    for (int i = 0; i <= delay; i++) begin
      chk("req_busy", 32'(dmem_req), 32'd1);
      chk("addr", dmem_addr, {ma[31:2], 2'b00});
      chk("be", 32'(dmem_be), 32'(ebe));
      chk("we", 32'(dmem_we), 32'(wr));
      if (wr) chk("wdata", dmem_wdata, ewd);
      if (stall_m) nstall++;
      if (i < delay) tick();
    end
    dmem_rdata = rdat;
    dmem_ack   = 1'b1;
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    exp_rd     = wr ? 32'd0 : ld;
    #1;
    chk("stall_done", 32'(stall_m), 32'd0);
    chk("req_done", 32'(dmem_req), 32'd0);
    chk("rd_done", readdata_m, exp_rd);
    chk("stall_cycles", 32'(nstall), 32'(2 + delay));
    tick();
    memread_m  = 1'b0;
    memwrite_m = 1'b0;
    #1;
    chk("stall_after", 32'(stall_m), 32'd0);
    chk("rd_hold", readdata_m, exp_rd);
  endtask

  initial begin
    logic [2:0] ld_f3 [6];
    int         kind;
    logic [2:0] f3;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

    rst = 1'b1; memread_m = 1'b0; memwrite_m = 1'b0; funct3_m = 3'd0;
    aluresult_m = 32'd0; writedata_m = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
    exp_rd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_m), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_rd", readdata_m, 32'd0);
    rst = 1'b0;
    tick();

    do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0);
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'd0, 0);
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'd0, 32'h1234_8001, 5);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'hA5A5_5A5A, 1);
    do_access(1'b1, 1'b1, 3'b000, 32'h0000_0031, 32'h0000_00C3, 32'd0, 0);
    do_access(1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'd0, 32'd0, 0);

    // Reset while the memory is still working on a load; its late ack must vanish.
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 32'h1357_9BDF, 0);
    memread_m = 1'b1; funct3_m = 3'b010; aluresult_m = 32'h0000_0044;
    tick();
    chk("busy_before_rst", 32'(dmem_req), 32'd1);
    memread_m = 1'b0;
    #1 rst = 1'b1;
    #1;
    exp_rd = 32'd0;
    chk("async_rst_req", 32'(dmem_req), 32'd0);
    chk("async_rst_stall", 32'(stall_m), 32'd0);
    chk("async_rst_be", 32'(dmem_be), 32'd0);
    chk("async_rst_rd", readdata_m, 32'd0);
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    chk("late_ack_req", 32'(dmem_req), 32'd0);
    chk("late_ack_stall", 32'(stall_m), 32'd0);
    chk("late_ack_rd", readdata_m, 32'd0);
    do_access(1'b1, 1'b0, 3'b100, 32'h0000_0046, 32'd0, 32'h00F1_0000, 2);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) f3 = ld_f3[$urandom_range(0, 5)];
      else           f3 = 3'($urandom_range(0, 3));
      do_access(kind != 1, kind != 0, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, datapath and address width; only 32 is supported.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
REQ-003 The block SHALL expose the following ports:
- memread_m  in  1  load in M stage.
- memwrite_m  in  1  store in M stage.
- funct3_m  in  3  RISC-V size/sign field.
- aluresult_m  in  32  effective byte address.
- writedata_m  in  32  store data (rs2).
- readdata_m  out  32  extended load data, to MEM/WB register.
- stall_m  out  1  hold F/D/E/M stages.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  memory read word.
- dmem_ack  in  1  one-cycle completion pulse.
- misalign_m  out  1  misaligned access flag (LSU_MISALIGN_TRAP_EN only).

Function
REQ-004 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-005 In IDLE with memread_m|memwrite_m and a legal access, the block SHALL assert stall_m combinationally, register addr/wdata/be/we/funct3, and enter BUSY.
REQ-006 In BUSY, dmem_req SHALL be 1 and dmem_addr/dmem_wdata/dmem_be/dmem_we SHALL be stable, stall_m SHALL be 1, and the block SHALL remain in BUSY until dmem_ack.
REQ-007 On dmem_ack in BUSY, the block SHALL register the extended load result into readdata_m and enter DONE; dmem_req SHALL drop in the next cycle.
REQ-008 In DONE, stall_m SHALL be 0, readdata_m SHALL hold the load result, no new request SHALL start, and the next state SHALL be IDLE.
REQ-009 Minimum residency of one access in M SHALL be 3 cycles: IDLE, BUSY with ack, DONE.
REQ-010 When memread_m and memwrite_m are both 1, the access SHALL be treated as a store.
REQ-011 Byte enables SHALL be set as follows:
- funct3[1:0]=00: one lane at addr[1:0].
- funct3[1:0]=01: lanes {addr[1],0}+1..0.
- funct3[1:0]=10: all four lanes.
- funct3[1:0]=11: no request issued, no stall, treated as a no-op.
REQ-012 Store data SHALL be replicated per size: byte into all 4 lanes, half into both halves.
REQ-013 Load extraction SHALL select the addressed lane(s) and sign-extend for LB/LH (000/001) or zero-extend for LBU/LHU (100/101); LW passes the word through.
REQ-014 readdata_m SHALL be 0 after a store and SHALL hold its value otherwise until the next load completes.
REQ-015 dmem_addr SHALL be {aluresult_m[31:2],2'b00}.

Reset
REQ-016 Asserting rst, including mid-BUSY, SHALL immediately force IDLE and set dmem_req=0, dmem_we=0, dmem_be=0, stall_m=0 (absent an op), readdata_m=0, and misalign_m=0; a pending ack is discarded.

Configuration
REQ-017 With LSU_MISALIGN_TRAP_EN defined, the block SHALL behave as follows:
- Half access with addr[0]=1, or word access with addr[1:0]!=0, SHALL issue no request and SHALL NOT stall.
- misalign_m SHALL pulse for 1 cycle (registered) and readdata_m SHALL be set to 0.
REQ-018 Without LSU_MISALIGN_TRAP_EN, misalign_m SHALL be absent, and misaligned accesses SHALL have addr low bits masked to natural alignment and proceed normally.

Structure
REQ-019 Package lsu_pkg SHALL hold the FSM state enum and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-020 Combinational lane extraction/extension SHALL live in sub-module lsu_load_align.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- LB at addr 0x103, ack 1 cycle after req, rdata 0x80FF_0000 -> readdata_m=0xFFFF_FF80, stall high for exactly 2 cycles.
- SH at addr 0x202, wdata 0x0000_BEEF -> dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, addr 0x200.
- LHU at 0x10 with ack delayed 5 cycles -> req and addr stable for 5 cycles, readdata_m=0x0000_8001 for rdata 0x1234_8001.
- rst asserted in BUSY -> dmem_req=0 asynchronously; a later ack is ignored and the state is IDLE.
- LW at 0x6 with LSU_MISALIGN_TRAP_EN -> no dmem_req, misalign_m pulses once, and stall_m stays 0; without the macro -> request to 0x4, be=4'b1111.
